// File: rtl/pu_dot_sequencer.sv
// Sequencer feeding a two-multiplier/two-adder FP accumulate unit, one beat at a time.
// Optional abort port pair is built in when PU_SEQ_ABORT_EN is defined.
module pu_dot_sequencer #(
  parameter int LEN_W  = 8,
  parameter int PU_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PU_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a0,
  input  logic [31:0]      in_a1,
  input  logic [31:0]      in_b0,
  input  logic [31:0]      in_b1,
  output logic [31:0]      pu_prev,
  output logic [31:0]      pu_a0,
  output logic [31:0]      pu_a1,
  output logic [31:0]      pu_b0,
  output logic [31:0]      pu_b1,
  input  logic [31:0]      pu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             busy
);

  localparam int WAIT_W = (PU_LAT > 0) ? $clog2(PU_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PU_LAT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   beats_left;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [31:0]        acc;
  logic [31:0]        op_a0, op_a1, op_b0, op_b1;
  logic               kill;

`ifdef PU_SEQ_ABORT_EN
  assign kill = abort && (state != S_IDLE);
`else
  assign kill = 1'b0;
`endif

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_IDLE: if (start) state_nxt = (len == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_WAIT;
      end
      S_WAIT:
        if (wait_cnt == WAIT_LAST)
          state_nxt = (beats_left == LEN_W'(1)) ? S_DONE : S_RUN;
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides everything, including a pending result.
    if (kill) begin
      state_nxt = S_IDLE;
      in_ready  = 1'b0;
      res_valid = 1'b0;
    end
  end

  // NOTE: the operand and accumulator registers are reset too, because they
  // drive pu_* and res_data directly and must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      op_a0      <= '0;
      op_a1      <= '0;
      op_b0      <= '0;
      op_b1      <= '0;
      beats_left <= '0;
      wait_cnt   <= '0;
    end else if (kill) begin
      acc        <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (start) begin
            acc        <= '0;
            beats_left <= len;
            wait_cnt   <= '0;
          end
        S_RUN:
          if (in_valid) begin
            op_a0    <= in_a0;
            op_a1    <= in_a1;
            op_b0    <= in_b0;
            op_b1    <= in_b1;
            wait_cnt <= '0;
          end
        S_WAIT:
          if (wait_cnt == WAIT_LAST) begin
            acc        <= pu_out;
            beats_left <= beats_left - 1'b1;
          end else begin
            wait_cnt   <= wait_cnt + 1'b1;
          end
        default: ;
      endcase
    end
  end

`ifdef PU_SEQ_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) aborted <= 1'b0;
    else     aborted <= kill;
  end
`endif

  assign pu_prev  = acc;
  assign pu_a0    = op_a0;
  assign pu_a1    = op_a1;
  assign pu_b0    = op_b0;
  assign pu_b1    = op_b1;
  assign res_data = acc;

endmodule

// File: tb/tb_pu_dot_sequencer.sv
// Directed bench for pu_dot_sequencer: one instance with PU_LAT=0 and one with PU_LAT=2,
// each closed by a behavioural fp32 datapath model. Abort checks only when PU_SEQ_ABORT_EN is set.
module tb_pu_dot_sequencer;

  localparam logic [31:0] A0 = 32'h3F80_0000, B0 = 32'h4000_0000;
  localparam logic [31:0] A1 = 32'h4040_0000, B1 = 32'h4080_0000;
  localparam logic [31:0] R14 = 32'h4160_0000, R28 = 32'h41E0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] len = '0;
  logic in_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [31:0] in_a0 = A0, in_a1 = A1, in_b0 = B0, in_b1 = B1;
  logic abort = 1'b0;

  logic in_ready0, res_valid0, busy0, aborted0;
  logic [31:0] pu_prev0, pu_a0_0, pu_a1_0, pu_b0_0, pu_b1_0, pu_out0, res_data0;
  logic in_ready2, res_valid2, busy2, aborted2;
  logic [31:0] pu_prev2, pu_a0_2, pu_a1_2, pu_b0_2, pu_b1_2, pu_out2, res_data2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int e;
    if (b[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    m = m * (2.0 ** real'(e));
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int e;
    real a;
    logic [22:0] f;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    f = 23'(longint'((a - 1.0) * 8388608.0));
    return {s, 8'(e + 127), f};
  endfunction

  function automatic logic [31:0] dp(input logic [31:0] p, a0, b0, a1, b1);
    return r2f((f2r(p) + f2r(a0) * f2r(b0)) + f2r(a1) * f2r(b1));
  endfunction

  assign pu_out0 = dp(pu_prev0, pu_a0_0, pu_b0_0, pu_a1_0, pu_b1_0);
  assign pu_out2 = dp(pu_prev2, pu_a0_2, pu_b0_2, pu_a1_2, pu_b1_2);

  pu_dot_sequencer #(.LEN_W(8), .PU_LAT(0)) dut (
    .clk(clk), .rst(rst),
`ifdef PU_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted0),
`endif
    .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .pu_prev(pu_prev0), .pu_a0(pu_a0_0), .pu_a1(pu_a1_0), .pu_b0(pu_b0_0), .pu_b1(pu_b1_0),
    .pu_out(pu_out0),
    .res_valid(res_valid0), .res_ready(res_ready), .res_data(res_data0), .busy(busy0)
  );

  pu_dot_sequencer #(.LEN_W(8), .PU_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
`ifdef PU_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted2),
`endif
    .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .pu_prev(pu_prev2), .pu_a0(pu_a0_2), .pu_a1(pu_a1_2), .pu_b0(pu_b0_2), .pu_b1(pu_b1_2),
    .pu_out(pu_out2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2), .busy(busy2)
  );

`ifndef PU_SEQ_ABORT_EN
  assign aborted0 = 1'b0;
  assign aborted2 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic kick(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  // Cycles from the start cycle to the first res_valid, bounded.
  task automatic wait_res(input bit sel, output int cyc);
    cyc = 1;
    while (!(sel ? res_valid2 : res_valid0) && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc, ready_hi;
    logic stable, seen;
    logic [31:0] held;

    // Reset state
    do_reset();
    chk("rst_in_ready", 32'(in_ready0), 32'd0);
    chk("rst_res_valid", 32'(res_valid0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_res_data", res_data0, 32'h0);
    chk("rst_pu_prev", pu_prev0, 32'h0);
    chk("rst_pu_a0", pu_a0_0, 32'h0);

    // Single beat, PU_LAT=0
    in_valid = 1'b1;
    res_ready = 1'b1;
    kick(8'd1);
    wait_res(1'b0, cyc);
    chk("single_latency", 32'(cyc), 32'd3);
    chk("single_data", res_data0, R14);
    tick();
    chk("single_valid_drop", 32'(res_valid0), 32'd0);
    chk("single_idle", 32'(busy0), 32'd0);

    // Two beats, same operands
    do_reset();
    kick(8'd2);
    chk("two_c1_ready", 32'(in_ready0), 32'd1);
    tick();
    chk("two_c2_ready", 32'(in_ready0), 32'd0);
    tick();
    chk("two_c3_ready", 32'(in_ready0), 32'd1);
    tick();
    chk("two_wait2_prev", pu_prev0, R14);
    chk("two_wait2_ready", 32'(in_ready0), 32'd0);
    tick();
    chk("two_valid", 32'(res_valid0), 32'd1);
    chk("two_data", res_data0, R28);
    chk("two_done_ready", 32'(in_ready0), 32'd0);
    tick();

    // Backpressure on both sides, plus start ignored outside IDLE
    do_reset();
    in_valid = 1'b0;
    res_ready = 1'b0;
    kick(8'd1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd5;
      tick();
    end
    start = 1'b0;
    chk("bp_still_run", 32'(in_ready0), 32'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_wait_ready", 32'(in_ready0), 32'd0);
    tick();
    chk("bp_valid", 32'(res_valid0), 32'd1);
    chk("bp_data", res_data0, R14);
    held = res_data0;
    stable = 1'b1;
    ready_hi = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!res_valid0 || res_data0 !== held) stable = 1'b0;
      if (in_ready0) ready_hi++;
    end
    chk("bp_hold_stable", 32'(stable), 32'd1);
    chk("bp_no_reaccept", 32'(ready_hi), 32'd0);
    res_ready = 1'b1;
    start = 1'b1;
    len = 8'd0;
    tick();
    start = 1'b0;
    chk("bp_valid_drop", 32'(res_valid0), 32'd0);
    chk("bp_start_ignored", 32'(busy0), 32'd0);
    tick();
    chk("bp_no_second_result", 32'(res_valid0), 32'd0);

    // Zero length: acc still holds the previous result, so the clear is visible
    kick(8'd0);
    chk("zero_valid", 32'(res_valid0), 32'd1);
    chk("zero_data", res_data0, 32'h0);
    chk("zero_in_ready", 32'(in_ready0), 32'd0);
    tick();
    chk("zero_valid_drop", 32'(res_valid0), 32'd0);

    // Reset mid-job on the PU_LAT=2 instance, during its second WAIT
    do_reset();
    in_valid = 1'b1;
    res_ready = 1'b1;
    kick(8'd3);
    repeat (6) tick();
    chk("mid_prev_wait2", pu_prev2, R14);
    chk("mid_busy", 32'(busy2), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy2), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready2), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid2), 32'd0);
    chk("mid_rst_res_data", res_data2, 32'h0);
    chk("mid_rst_pu_prev", pu_prev2, 32'h0);
    chk("mid_rst_pu_ops", pu_a0_2 | pu_a1_2 | pu_b0_2 | pu_b1_2, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid2 || busy2) seen = 1'b1;
    end
    chk("mid_no_result", 32'(seen), 32'd0);
    kick(8'd1);
    wait_res(1'b1, cyc);
    chk("lat2_latency", 32'(cyc), 32'd5);
    chk("lat2_data", res_data2, R14);
    tick();

`ifdef PU_SEQ_ABORT_EN
    // Abort in RUN of beat 2
    do_reset();
    in_valid = 1'b1;
    res_ready = 1'b1;
    kick(8'd2);
    tick();
    tick();
    chk("ab_in_run", 32'(in_ready0), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_pulse", 32'(aborted0), 32'd1);
    chk("ab_busy", 32'(busy0), 32'd0);
    chk("ab_acc_clear", pu_prev0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid0) seen = 1'b1;
      tick();
    end
    chk("ab_pulse_one", 32'(aborted0), 32'd0);
    chk("ab_no_result", 32'(seen), 32'd0);
    rst = 1'b1;
    abort = 1'b1;
    tick();
    rst = 1'b0;
    abort = 1'b0;
    chk("ab_rst_wins", 32'(aborted0), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
